// File: rtl/memory_stage_pkg.sv
// Shared encodings, stage-register layout and alignment helpers for the
// MEM pipeline stage. Bit numbering is big-endian at the spec level: byte
// lane 0 is the most significant byte of a 32-bit word.
package memory_stage_pkg;

    typedef enum logic [1:0] {
        DIN_ALU = 2'b00,
        DIN_MEM = 2'b01,
        DIN_FPU = 2'b10,
        DIN_PC  = 2'b11
    } din_src_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11   // decoded exactly like SZ_WORD
    } mem_size_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    // Everything the stage latches from Execute in one capture.
    typedef struct packed {
        logic [31:0] alu_out;
        logic [31:0] fpu_out;
        logic [31:0] reg_b;
        logic [31:0] pc_plus_four;
        din_src_e    din_src;
        logic        reg_we;
        logic [5:0]  reg_waddr;
        mem_size_e   mem_size;
        logic        mem_we;
        logic        ext_mem;
    } stage_t;

    // Stores and loads both touch data memory.
    function automatic logic is_access(input logic mem_we, input din_src_e din_src);
        return mem_we || (din_src == DIN_MEM);
    endfunction

    // lane is the two low address bits (big-endian bits [30:31]).
    function automatic logic is_misaligned(input mem_size_e size, input logic [1:0] lane);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return lane[0];
            default: return lane != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/memory_stage_mem_align.sv
// Combinational lane steering for the MEM stage: store-data replication,
// byte enables (MSB of byte_en = lane 0) and load extract/extend.
module mem_align
    import memory_stage_pkg::*;
(
    input  mem_size_e   size,
    input  logic [1:0]  lane,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    input  logic        sign_ext,
    output logic [31:0] wdata,
    output logic [3:0]  byte_en,
    output logic [31:0] load_data
);

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    // Pick the addressed byte and half out of the big-endian read word.
    always_comb begin
        case (lane)
            2'd0:    rd_byte = rdata[31:24];
            2'd1:    rd_byte = rdata[23:16];
            2'd2:    rd_byte = rdata[15:8];
            default: rd_byte = rdata[7:0];
        endcase
        rd_half = lane[1] ? rdata[15:0] : rdata[31:16];
    end

    // Replicate store data across lanes, build enables, extend load data.
    always_comb begin
        // NOTE: every output gets a default before the case so no path can infer a latch.
        wdata     = store_data;
        byte_en   = 4'b1111;
        load_data = rdata;
        case (size)
            SZ_BYTE: begin
                wdata     = {4{store_data[7:0]}};
                byte_en   = 4'b1000 >> lane;
                load_data = {{24{sign_ext & rd_byte[7]}}, rd_byte};
            end
            SZ_HALF: begin
                wdata     = {2{store_data[15:0]}};
                byte_en   = lane[1] ? 4'b0011 : 4'b1100;
                load_data = {{16{sign_ext & rd_half[15]}}, rd_half};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/memory_stage.sv
// MEM pipeline stage: latches Execute results, runs one outstanding
// req/ack data-memory access for loads/stores, aligns load data and
// forwards writeback control. Optional ack timeout: MEM_TIMEOUT_EN.
module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [31:0] NextALUOut,
    input  logic [31:0] NextFPUOut,
    input  logic [31:0] NextRegB,
    input  logic [31:0] NextPCPlusFour,
    input  logic [1:0]  NextDInSrc,
    input  logic        NextRegWE,
    input  logic [5:0]  NextRegWAddr,
    input  logic [1:0]  NextMEMSize,
    input  logic        NextMEMWE,
    input  logic        NextExtMEM,
    output logic        MemReq,
    output logic        MemWE,
    output logic [31:0] MemAddr,
    output logic [31:0] MemWData,
    output logic [3:0]  MemByteEn,
    input  logic        MemAck,
    input  logic [31:0] MemRData,
    output logic        MemStall,
    output logic        MisalignErr,
    output logic        MemTimeout,
    output logic [31:0] ALUOut,
    output logic [31:0] FPUOut,
    output logic [31:0] PCPlusFour,
    output logic [31:0] MemData,
    output logic [1:0]  DInSrc,
    output logic        RegWE,
    output logic [5:0]  RegWAddr
);

    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    stage_t      stage_q, stage_d;
    state_e      state_q, state_d;
    logic        misalign_q, misalign_d;
    logic [31:0] mem_data_q, mem_data_d;

    logic        capture;
    logic        busy;
    logic        next_access;
    logic        next_misaligned;
    logic        stage_misaligned;
    logic        timeout_hit;
    logic        wb_kill;
    logic [31:0] lane_wdata;
    logic [3:0]  lane_be;
    logic [31:0] lane_rdata;

    assign capture          = (state_q == ST_IDLE) && !stall;
    assign busy             = (state_q == ST_BUSY);
    assign next_access      = is_access(NextMEMWE, din_src_e'(NextDInSrc));
    assign next_misaligned  = is_misaligned(mem_size_e'(NextMEMSize), NextALUOut[1:0]);
    assign stage_misaligned = is_access(stage_q.mem_we, stage_q.din_src)
                              && is_misaligned(stage_q.mem_size, stage_q.alu_out[1:0]);

    mem_align u_mem_align (
        .size       (stage_q.mem_size),
        .lane       (stage_q.alu_out[1:0]),
        .store_data (stage_q.reg_b),
        .rdata      (MemRData),
        .sign_ext   (stage_q.ext_mem),
        .wdata      (lane_wdata),
        .byte_en    (lane_be),
        .load_data  (lane_rdata)
    );

    // Capture Execute results, sequence the access, latch load data on ack.
    always_comb begin
        stage_d    = stage_q;
        state_d    = state_q;
        misalign_d = 1'b0;
        mem_data_d = mem_data_q;
        case (state_q)
            ST_IDLE: begin
                if (!stall) begin
                    stage_d.alu_out      = NextALUOut;
                    stage_d.fpu_out      = NextFPUOut;
                    stage_d.reg_b        = NextRegB;
                    stage_d.pc_plus_four = NextPCPlusFour;
                    stage_d.din_src      = din_src_e'(NextDInSrc);
                    stage_d.reg_we       = NextRegWE;
                    stage_d.reg_waddr    = NextRegWAddr;
                    stage_d.mem_size     = mem_size_e'(NextMEMSize);
                    stage_d.mem_we       = NextMEMWE;
                    stage_d.ext_mem      = NextExtMEM;
                    if (next_access && next_misaligned) begin
                        misalign_d = 1'b1;
                    end else if (next_access) begin
                        state_d = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                // stall is deliberately ignored here: the access always completes.
                if (MemAck) begin
                    state_d = ST_IDLE;
                    if (!stage_q.mem_we) begin
                        mem_data_d = lane_rdata;
                    end
                end else if (timeout_hit) begin
                    state_d    = ST_IDLE;
                    mem_data_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Stage, FSM, misalign pulse and load-result registers.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!reset) begin
            stage_q    <= '0;
            state_q    <= ST_IDLE;
            misalign_q <= 1'b0;
            mem_data_q <= '0;
        end else begin
            stage_q    <= stage_d;
            state_q    <= state_d;
            misalign_q <= misalign_d;
            mem_data_q <= mem_data_d;
        end
    end

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                                    $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;
    logic             wb_kill_q, wb_kill_d;

    // Abort on the BUSY cycle whose count would reach TIMEOUT_CYCLES.
    assign timeout_hit = busy && !MemAck && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Wait counter, sticky timeout flag and writeback kill for the aborted op.
    always_comb begin
        cnt_d     = cnt_q;
        timeout_d = timeout_q || timeout_hit;
        wb_kill_d = wb_kill_q;
        if (capture) begin
            cnt_d     = '0;
            wb_kill_d = 1'b0;
        end else if (busy && !MemAck) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (timeout_hit) begin
            wb_kill_d = 1'b1;
        end
    end

    // Timeout bookkeeping registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
            wb_kill_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
            wb_kill_q <= wb_kill_d;
        end
    end

    assign wb_kill    = wb_kill_q;
    assign MemTimeout = timeout_q;
`else
    assign timeout_hit = 1'b0;
    assign wb_kill     = 1'b0;
    assign MemTimeout  = 1'b0;
`endif

    // Memory interface is driven only while an access is in flight; the
    // stage register holds in BUSY, so address/data/enables stay stable.
    assign MemReq    = busy;
    assign MemStall  = busy;
    assign MemWE     = busy & stage_q.mem_we;
    assign MemAddr   = busy ? {stage_q.alu_out[31:2], 2'b00} : '0;
    assign MemWData  = busy ? lane_wdata : '0;
    assign MemByteEn = busy ? lane_be : '0;

    assign MisalignErr = misalign_q;
    assign ALUOut      = stage_q.alu_out;
    assign FPUOut      = stage_q.fpu_out;
    assign PCPlusFour  = stage_q.pc_plus_four;
    assign MemData     = mem_data_q;
    assign DInSrc      = stage_q.din_src;
    assign RegWAddr    = stage_q.reg_waddr;
    assign RegWE       = stage_q.reg_we & ~busy & ~stage_misaligned & ~wb_kill;

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: directed vector table, hand-written
// stall/reset/timeout sequences, and randomized ops checked against a
// byte-lane reference model.
module tb_memory_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        stall;
    logic [31:0] NextALUOut, NextFPUOut, NextRegB, NextPCPlusFour;
    logic [1:0]  NextDInSrc;
    logic        NextRegWE;
    logic [5:0]  NextRegWAddr;
    logic [1:0]  NextMEMSize;
    logic        NextMEMWE, NextExtMEM;
    logic        MemReq, MemWE;
    logic [31:0] MemAddr, MemWData;
    logic [3:0]  MemByteEn;
    logic        MemAck;
    logic [31:0] MemRData;
    logic        MemStall, MisalignErr, MemTimeout;
    logic [31:0] ALUOut, FPUOut, PCPlusFour, MemData;
    logic [1:0]  DInSrc;
    logic        RegWE;
    logic [5:0]  RegWAddr;

    memory_stage #(.TIMEOUT_CYCLES(255)) dut (
        .clk(clk), .reset(reset), .stall(stall),
        .NextALUOut(NextALUOut), .NextFPUOut(NextFPUOut), .NextRegB(NextRegB),
        .NextPCPlusFour(NextPCPlusFour), .NextDInSrc(NextDInSrc), .NextRegWE(NextRegWE),
        .NextRegWAddr(NextRegWAddr), .NextMEMSize(NextMEMSize), .NextMEMWE(NextMEMWE),
        .NextExtMEM(NextExtMEM), .MemReq(MemReq), .MemWE(MemWE), .MemAddr(MemAddr),
        .MemWData(MemWData), .MemByteEn(MemByteEn), .MemAck(MemAck), .MemRData(MemRData),
        .MemStall(MemStall), .MisalignErr(MisalignErr), .MemTimeout(MemTimeout),
        .ALUOut(ALUOut), .FPUOut(FPUOut), .PCPlusFour(PCPlusFour), .MemData(MemData),
        .DInSrc(DInSrc), .RegWE(RegWE), .RegWAddr(RegWAddr)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] model_mem_data;

    typedef struct {
        string       name;
        logic [31:0] alu, fpu, regb, pc4;
        logic [1:0]  din;
        logic        regwe;
        logic [5:0]  waddr;
        logic [1:0]  size;
        logic        memwe;
        logic        ext;
        int          ack_lat;
        logic [31:0] rdata;
        logic        exp_mis;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_mem_data;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    function automatic vec_t mk(input string name, input logic [31:0] alu, input logic [31:0] regb,
                                input logic [1:0] din, input logic regwe, input logic [1:0] size,
                                input logic memwe, input logic ext, input int lat,
                                input logic [31:0] rdata, input logic mis, input logic [3:0] be,
                                input logic [31:0] wdata, input logic [31:0] md);
        vec_t v;
        v.name = name; v.alu = alu; v.fpu = ~alu; v.regb = regb; v.pc4 = alu + 32'd4;
        v.din = din; v.regwe = regwe; v.waddr = alu[5:0] ^ 6'h2A; v.size = size;
        v.memwe = memwe; v.ext = ext; v.ack_lat = lat; v.rdata = rdata;
        v.exp_mis = mis; v.exp_be = be; v.exp_wdata = wdata; v.exp_mem_data = md;
        return v;
    endfunction

    // ---------------- reference model (byte-lane arithmetic) ----------------
    function automatic int nbytes_of(input logic [1:0] size);
        if (size == 2'd0) return 1;
        if (size == 2'd1) return 2;
        return 4;
    endfunction

    function automatic int start_lane(input logic [1:0] size, input logic [31:0] addr);
        int n = nbytes_of(size);
        int k = int'(addr % 32'd4);
        return (k / n) * n;
    endfunction

    function automatic logic [3:0] model_be(input logic [1:0] size, input logic [31:0] addr);
        logic [3:0] be = '0;
        int n = nbytes_of(size);
        int s = start_lane(size, addr);
        for (int ln = 0; ln < 4; ln++)
            if (ln >= s && ln < s + n) be[3 - ln] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [1:0] size, input logic [31:0] data);
        int n = nbytes_of(size);
        longint unsigned mask = (64'd1 << (8 * n)) - 64'd1;
        longint unsigned low = longint'(data) & mask;
        longint unsigned w = 0;
        for (int i = 0; i < 4 / n; i++) w = (w << (8 * n)) | low;
        return w[31:0];
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] size, input logic [31:0] addr,
                                               input logic [31:0] rdata, input logic ext);
        int n = nbytes_of(size);
        int s = start_lane(size, addr);
        longint unsigned mask = (64'd1 << (8 * n)) - 64'd1;
        longint unsigned val = (longint'(rdata) >> (8 * (4 - s - n))) & mask;
        longint sv = longint'(val);
        logic [63:0] full;
        if (ext && val > (mask >> 1)) sv = sv - longint'(mask + 64'd1);
        full = 64'(sv);
        return full[31:0];
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic drive_nop();
        NextALUOut = '0; NextFPUOut = '0; NextRegB = '0; NextPCPlusFour = '0;
        NextDInSrc = 2'b00; NextRegWE = 1'b0; NextRegWAddr = '0; NextMEMSize = 2'b00;
        NextMEMWE = 1'b0; NextExtMEM = 1'b0;
    endtask

    task automatic drive_vec(input vec_t v);
        NextALUOut = v.alu; NextFPUOut = v.fpu; NextRegB = v.regb; NextPCPlusFour = v.pc4;
        NextDInSrc = v.din; NextRegWE = v.regwe; NextRegWAddr = v.waddr; NextMEMSize = v.size;
        NextMEMWE = v.memwe; NextExtMEM = v.ext;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        logic access;
        logic stable;
        int   busy;
        access = v.memwe || (v.din == 2'b01);
        @(negedge clk);
        stall = 1'b0; MemAck = 1'b0;
        drive_vec(v);
        @(negedge clk);
        drive_nop();
        if (access && !v.exp_mis) begin
            check({tag, ".req"}, 32'(MemReq), 32'd1);
            check({tag, ".we"}, 32'(MemWE), 32'(v.memwe));
            check({tag, ".addr"}, MemAddr, v.alu & 32'hFFFF_FFFC);
            check({tag, ".be"}, 32'(MemByteEn), 32'(v.exp_be));
            if (v.memwe) check({tag, ".wdata"}, MemWData, v.exp_wdata);
            check({tag, ".regwe_busy"}, 32'(RegWE), 32'd0);
            busy = 0; stable = 1'b1;
            while (MemStall && busy < 64) begin
                busy++;
                if (MemAddr !== (v.alu & 32'hFFFF_FFFC) || MemByteEn !== v.exp_be) stable = 1'b0;
                if (busy == v.ack_lat) begin
                    MemAck = 1'b1; MemRData = v.rdata;
                end else begin
                    MemAck = 1'b0; MemRData = $urandom;
                end
                @(negedge clk);
                MemAck = 1'b0;
            end
            check({tag, ".busy_cycles"}, 32'(busy), 32'(v.ack_lat));
            check({tag, ".stable"}, 32'(stable), 32'd1);
            check({tag, ".req_done"}, 32'(MemReq), 32'd0);
            check({tag, ".regwe_after"}, 32'(RegWE), 32'(v.regwe));
            check({tag, ".waddr"}, 32'(RegWAddr), 32'(v.waddr));
        end else begin
            check({tag, ".req"}, 32'(MemReq), 32'd0);
            check({tag, ".misalign"}, 32'(MisalignErr), 32'(v.exp_mis));
            check({tag, ".regwe"}, 32'(RegWE), 32'(v.regwe & ~v.exp_mis));
            check({tag, ".alu"}, ALUOut, v.alu);
            check({tag, ".fpu"}, FPUOut, v.fpu);
            check({tag, ".pc4"}, PCPlusFour, v.pc4);
            check({tag, ".din"}, 32'(DInSrc), 32'(v.din));
            check({tag, ".waddr"}, 32'(RegWAddr), 32'(v.waddr));
            if (v.exp_mis) begin
                @(negedge clk);
                check({tag, ".misalign_end"}, 32'(MisalignErr), 32'd0);
                check({tag, ".req_never"}, 32'(MemReq), 32'd0);
            end
        end
        check({tag, ".mem_data"}, MemData, v.exp_mem_data);
    endtask

    task automatic start_word_load(input logic [31:0] addr);
        @(negedge clk);
        stall = 1'b0; MemAck = 1'b0;
        drive_nop();
        NextALUOut = addr; NextDInSrc = 2'b01; NextRegWE = 1'b1; NextRegWAddr = 6'd3;
        NextMEMSize = 2'b10;
        @(negedge clk);
        drive_nop();
    endtask

    initial begin
        vec_t v;
        int   kind;
        int   busy;
        logic mis;

        vecs[0]  = mk("st_word",    32'h0000_0104, 32'hDEAD_BEEF, 2'b00, 1'b0, 2'b10, 1'b1, 1'b0, 2, 32'h0,
                      1'b0, 4'b1111, 32'hDEAD_BEEF, 32'h0000_0000);
        vecs[1]  = mk("ld_sbyte",   32'h0000_0203, 32'h0,         2'b01, 1'b1, 2'b00, 1'b0, 1'b1, 1, 32'h1122_33F0,
                      1'b0, 4'b0001, 32'h0,         32'hFFFF_FFF0);
        vecs[2]  = mk("ld_uhalf",   32'h0000_0202, 32'h0,         2'b01, 1'b1, 2'b01, 1'b0, 1'b0, 3, 32'hAAAA_8001,
                      1'b0, 4'b0011, 32'h0,         32'h0000_8001);
        vecs[3]  = mk("ld_mis_half",32'h0000_0201, 32'h0,         2'b01, 1'b1, 2'b01, 1'b0, 1'b0, 1, 32'h0,
                      1'b1, 4'b0000, 32'h0,         32'h0000_8001);
        vecs[4]  = mk("st_byte_l1", 32'h0000_0301, 32'h1234_56A5, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0, 1, 32'h0,
                      1'b0, 4'b0100, 32'hA5A5_A5A5, 32'h0000_8001);
        vecs[5]  = mk("st_half_l0", 32'h0000_0400, 32'h1234_BEEF, 2'b00, 1'b0, 2'b01, 1'b1, 1'b0, 2, 32'h0,
                      1'b0, 4'b1100, 32'hBEEF_BEEF, 32'h0000_8001);
        vecs[6]  = mk("ld_shalf_l0",32'h0000_0500, 32'h0,         2'b01, 1'b1, 2'b01, 1'b0, 1'b1, 2, 32'h9ABC_1234,
                      1'b0, 4'b1100, 32'h0,         32'hFFFF_9ABC);
        vecs[7]  = mk("ld_ubyte_l0",32'h0000_0600, 32'h0,         2'b01, 1'b1, 2'b00, 1'b0, 1'b0, 1, 32'h80FF_FFFF,
                      1'b0, 4'b1000, 32'h0,         32'h0000_0080);
        vecs[8]  = mk("ld_word",    32'h0000_0704, 32'h0,         2'b01, 1'b1, 2'b10, 1'b0, 1'b1, 4, 32'hCAFE_F00D,
                      1'b0, 4'b1111, 32'h0,         32'hCAFE_F00D);
        vecs[9]  = mk("ld_rsvd",    32'h0000_0708, 32'h0,         2'b01, 1'b1, 2'b11, 1'b0, 1'b0, 1, 32'h0123_4567,
                      1'b0, 4'b1111, 32'h0,         32'h0123_4567);
        vecs[10] = mk("st_mis_word",32'h0000_0802, 32'h1111_1111, 2'b00, 1'b1, 2'b10, 1'b1, 1'b0, 1, 32'h0,
                      1'b1, 4'b0000, 32'h0,         32'h0123_4567);
        vecs[11] = mk("alu_op",     32'h1111_2222, 32'h0,         2'b00, 1'b1, 2'b10, 1'b0, 1'b0, 1, 32'h0,
                      1'b0, 4'b0000, 32'h0,         32'h0123_4567);
        vecs[12] = mk("fpu_op",     32'h0000_0003, 32'h0,         2'b10, 1'b1, 2'b10, 1'b0, 1'b0, 1, 32'h0,
                      1'b0, 4'b0000, 32'h0,         32'h0123_4567);
        vecs[13] = mk("pc_op",      32'h0000_0001, 32'h0,         2'b11, 1'b0, 2'b01, 1'b0, 1'b0, 1, 32'h0,
                      1'b0, 4'b0000, 32'h0,         32'h0123_4567);

        // ---- reset ----
        stall = 1'b0; MemAck = 1'b0; MemRData = '0;
        drive_nop();
        reset = 1'b1;
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst.req", 32'(MemReq), 32'd0);
        check("rst.stall", 32'(MemStall), 32'd0);
        check("rst.misalign", 32'(MisalignErr), 32'd0);
        check("rst.timeout", 32'(MemTimeout), 32'd0);
        check("rst.regwe", 32'(RegWE), 32'd0);
        check("rst.alu", ALUOut, 32'd0);
        check("rst.mem_data", MemData, 32'd0);
        check("rst.be", 32'(MemByteEn), 32'd0);
        reset = 1'b1;

        // ---- directed vector table ----
        foreach (vecs[i]) run_vec(vecs[i], vecs[i].name);

        // ---- stall holds an ALU op, release captures the next ----
        @(negedge clk);
        drive_nop();
        NextALUOut = 32'hA5A5_0001; NextRegWE = 1'b1; NextRegWAddr = 6'd9;
        @(negedge clk);
        check("stall.cap_alu", ALUOut, 32'hA5A5_0001);
        NextALUOut = 32'h5A5A_0002; NextRegWAddr = 6'd10;
        stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("stall.hold_alu%0d", c), ALUOut, 32'hA5A5_0001);
            check($sformatf("stall.hold_waddr%0d", c), 32'(RegWAddr), 32'd9);
            check($sformatf("stall.req%0d", c), 32'(MemReq), 32'd0);
        end
        stall = 1'b0;
        @(negedge clk);
        check("stall.next_alu", ALUOut, 32'h5A5A_0002);
        check("stall.next_waddr", 32'(RegWAddr), 32'd10);
        check("stall.next_req", 32'(MemReq), 32'd0);

        // ---- stall during BUSY is ignored ----
        start_word_load(32'h0000_0900);
        stall = 1'b1;
        check("busystall.req", 32'(MemReq), 32'd1);
        @(negedge clk);
        MemAck = 1'b1; MemRData = 32'h0BAD_F00D;
        @(negedge clk);
        MemAck = 1'b0;
        check("busystall.done", 32'(MemStall), 32'd0);
        check("busystall.mem_data", MemData, 32'h0BAD_F00D);
        check("busystall.regwe", 32'(RegWE), 32'd1);
        @(negedge clk);
        check("busystall.hold_alu", ALUOut, 32'h0000_0900);
        stall = 1'b0;
        model_mem_data = 32'h0BAD_F00D;

        // ---- randomized ops against the lane model ----
        for (int r = 0; r < 40; r++) begin
            kind = $urandom_range(0, 2);   // 0 non-access, 1 load, 2 store
            v.name = "rnd";
            v.alu = $urandom; v.fpu = $urandom; v.regb = $urandom; v.pc4 = $urandom;
            v.size = 2'($urandom_range(0, 3));
            v.regwe = 1'($urandom_range(0, 1));
            v.waddr = 6'($urandom);
            v.ext = 1'($urandom_range(0, 1));
            v.ack_lat = $urandom_range(1, 4);
            v.rdata = $urandom;
            v.memwe = (kind == 2);
            if (kind == 1) v.din = 2'b01;
            else begin
                v.din = 2'($urandom_range(0, 2));
                if (v.din == 2'b01) v.din = 2'b11;
            end
            mis = (kind != 0) && ((v.alu % 32'(nbytes_of(v.size))) != 32'd0);
            v.exp_mis = mis;
            v.exp_be = model_be(v.size, v.alu);
            v.exp_wdata = model_wdata(v.size, v.regb);
            if (kind == 1 && !mis) model_mem_data = model_load(v.size, v.alu, v.rdata, v.ext);
            v.exp_mem_data = model_mem_data;
            run_vec(v, $sformatf("rnd%0d", r));
        end

        // ---- ack never arrives: timeout or indefinite wait ----
        start_word_load(32'h0000_0A00);
        busy = 0;
        while (MemStall && busy < 400) begin
            busy++;
            @(negedge clk);
        end
`ifdef MEM_TIMEOUT_EN
        check("to.busy_cycles", 32'(busy), 32'd255);
        check("to.flag", 32'(MemTimeout), 32'd1);
        check("to.regwe", 32'(RegWE), 32'd0);
        check("to.mem_data", MemData, 32'd0);
        check("to.req", 32'(MemReq), 32'd0);
        @(negedge clk);
        check("to.sticky", 32'(MemTimeout), 32'd1);
`else
        check("noto.still_busy", 32'(busy), 32'd400);
        check("noto.flag", 32'(MemTimeout), 32'd0);
`endif
        if (!MemStall) begin
            start_word_load(32'h0000_0B00);
            repeat (2) @(negedge clk);
        end
        check("rstbusy.pre_req", 32'(MemReq), 32'd1);

        // ---- asynchronous reset in the middle of BUSY ----
        #2 reset = 1'b0;
        #1;
        check("rstbusy.req", 32'(MemReq), 32'd0);
        check("rstbusy.stall", 32'(MemStall), 32'd0);
        check("rstbusy.timeout", 32'(MemTimeout), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rstbusy.idle", 32'(MemStall), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
